// File: rtl/simon_pkg.sv
// Shared SIMON definitions: controller states, round-count table and the
// z-sequence constants used by the key-expansion datapath.
package simon_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    KLD  = 3'd1,
    KEXP = 3'd2,
    PLD  = 3'd3,
    RUN  = 3'd4,
    DONE = 3'd5
  } simon_state_t;

  // z-sequences, bit 61 is z[0]
  localparam logic [61:0] Z0 = 62'b11111010001001010110000111001101111101000100101011000011100110;
  localparam logic [61:0] Z1 = 62'b10001110111110010011000010110101000111011111001001100001011010;
  localparam logic [61:0] Z2 = 62'b10101111011100000011010010011000101000010001111110010110110011;
  localparam logic [61:0] Z3 = 62'b11011011101011000110010111100000010010001010011100110100001111;
  localparam logic [61:0] Z4 = 62'b11010001111001101011011000100000010111000011001010010011101111;

  // Standard round count for a (word size, key words) pair; 0 = unsupported.
  function automatic int simon_rounds(input int n, input int m);
    case ({n, m})
      {32'd16, 32'd4}: return 32;
      {32'd24, 32'd3}: return 36;
      {32'd24, 32'd4}: return 36;
      {32'd32, 32'd3}: return 42;
      {32'd32, 32'd4}: return 44;
      {32'd48, 32'd2}: return 52;
      {32'd48, 32'd3}: return 54;
      {32'd64, 32'd2}: return 68;
      {32'd64, 32'd3}: return 69;
      {32'd64, 32'd4}: return 72;
      default:         return 0;
    endcase
  endfunction

  // Which z-sequence a (word size, key words) pair uses.
  function automatic int simon_z_index(input int n, input int m);
    case ({n, m})
      {32'd16, 32'd4}: return 0;
      {32'd24, 32'd3}: return 0;
      {32'd24, 32'd4}: return 1;
      {32'd32, 32'd3}: return 2;
      {32'd32, 32'd4}: return 3;
      {32'd48, 32'd2}: return 2;
      {32'd48, 32'd3}: return 3;
      {32'd64, 32'd2}: return 2;
      {32'd64, 32'd3}: return 3;
      {32'd64, 32'd4}: return 4;
      default:         return 0;
    endcase
  endfunction

  // Bit i of the selected z-sequence.
  function automatic logic simon_z_bit(input int idx, input int i);
    logic [61:0] z;
    case (idx)
      0:       z = Z0;
      1:       z = Z1;
      2:       z = Z2;
      3:       z = Z3;
      default: z = Z4;
    endcase
    return z[61 - (i % 62)];
  endfunction

endpackage

// File: rtl/simon_round_counter.sv
// Loadable up/down round / key-slot counter with terminal-count flag.
// tc is the last value in the current direction: T-1 counting up, 0 down.
module simon_round_counter #(
  parameter int T  = 32,
  parameter int CW = $clog2(T)
) (
  input  logic          clk,
  input  logic          nReset,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  input  logic          en,
  input  logic          up,
  output logic [CW-1:0] count,
  output logic          tc
);

  localparam logic [CW-1:0] LAST = CW'(T - 1);

  // Count register: load has priority over stepping.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset)   count <= '0;
    else if (load) count <= load_val;
    else if (en)   count <= up ? count + 1'b1 : count - 1'b1;
  end

  assign tc = up ? (count == LAST) : (count == '0);

endmodule

// File: rtl/simon_control_2.sv
// SIMON (N, M, T) sequencing controller: key load, key expansion, block
// load and T Feistel rounds, encrypt or decrypt. The expanded schedule is
// kept (keyValid) so later blocks under the same key skip expansion.
// Optional build macro SIMON_CTRL_ABORT_EN adds an abort input.
module simon_control_2
  import simon_pkg::*;
#(
  parameter  int N  = 16,
  parameter  int M  = 4,
  parameter  int T  = 32,
  localparam int CW = $clog2(T)
) (
  input  logic          clk,
  input  logic          nReset,
  input  logic          start,
  input  logic          newKey,
  input  logic          enc_dec,
`ifdef SIMON_CTRL_ABORT_EN
  input  logic          abort,
`endif
  output logic          ready,
  output logic          busy,
  output logic          kLd,
  output logic          kExp,
  output logic          pLd,
  output logic          rnd,
  output logic [CW-1:0] count,
  output logic          keyValid,
  output logic          done
);

  localparam logic [CW-1:0] LAST      = CW'(T - 1);
  localparam logic [CW-1:0] KEY_FIRST = CW'(M);

  // Elaboration-time legality checks on the configuration.
  if (T <= M) begin : g_bad_rounds
    $error("simon_control_2: T must exceed M");
  end
  if (simon_rounds(N, M) == 0) begin : g_bad_shape
    $error("simon_control_2: unsupported (N, M) combination");
  end

  simon_state_t  state, next_state;
  logic          mode_reg;
  logic          mode_load;
  logic          kv_set, kv_clr;
  logic          cnt_load, cnt_en, cnt_up, cnt_tc;
  logic [CW-1:0] cnt_val;

  // Counter direction: rounds follow the latched mode, expansion counts up.
  assign cnt_up = (state == RUN) ? ~mode_reg : 1'b1;

  simon_round_counter #(.T(T), .CW(CW)) u_counter (
    .clk      (clk),
    .nReset   (nReset),
    .load     (cnt_load),
    .load_val (cnt_val),
    .en       (cnt_en),
    .up       (cnt_up),
    .count    (count),
    .tc       (cnt_tc)
  );

  // State register.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) state <= IDLE;
    else         state <= next_state;
  end

  // Next-state and counter/key-valid control.
  always_comb begin
    // NOTE: every output gets a default before the case so no path
    // leaves one unassigned, which would infer a latch.
    next_state = state;
    mode_load  = 1'b0;
    kv_set     = 1'b0;
    kv_clr     = 1'b0;
    cnt_load   = 1'b0;
    cnt_val    = '0;
    cnt_en     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          mode_load = 1'b1;
          if (newKey || !keyValid) begin
            next_state = KLD;
            kv_clr     = 1'b1;
          end else begin
            next_state = PLD;
          end
        end
      end
      KLD: begin
        cnt_load   = 1'b1;
        cnt_val    = KEY_FIRST;
        next_state = KEXP;
      end
      KEXP: begin
        if (cnt_tc) begin
          kv_set     = 1'b1;
          next_state = PLD;
        end else begin
          cnt_en = 1'b1;
        end
      end
      PLD: begin
        cnt_load   = 1'b1;
        cnt_val    = mode_reg ? LAST : '0;
        next_state = RUN;
      end
      RUN: begin
        if (cnt_tc) begin
          cnt_load   = 1'b1;
          cnt_val    = '0;
          next_state = DONE;
        end else begin
          cnt_en = 1'b1;
        end
      end
      DONE: begin
        cnt_load   = 1'b1;
        cnt_val    = '0;
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
        cnt_load   = 1'b1;
        cnt_val    = '0;
      end
    endcase
`ifdef SIMON_CTRL_ABORT_EN
    // Abort overrides everything outside IDLE; a half-built schedule is dropped.
    if (abort && state != IDLE) begin
      next_state = IDLE;
      cnt_load   = 1'b1;
      cnt_val    = '0;
      cnt_en     = 1'b0;
      kv_set     = 1'b0;
      kv_clr     = (state == KLD) || (state == KEXP);
    end
`endif
  end

  // Latched encrypt/decrypt mode for the whole operation.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset)        mode_reg <= 1'b0;
    else if (mode_load) mode_reg <= enc_dec;
  end

  // Key-schedule valid flag: cleared on a key load, set when expansion ends.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset)     keyValid <= 1'b0;
    else if (kv_clr) keyValid <= 1'b0;
    else if (kv_set) keyValid <= 1'b1;
  end

  // Moore strobes decoded from the state register.
  always_comb begin
    ready = (state == IDLE);
    busy  = (state != IDLE);
    kLd   = (state == KLD);
    kExp  = (state == KEXP);
    pLd   = (state == PLD);
    rnd   = (state == RUN);
    done  = (state == DONE);
  end

endmodule

// File: tb/tb_simon_control_2.sv
// Directed bench for simon_control_2: table of operations checked cycle by
// cycle, plus hand sequences for mid-run reset, forced key path and a
// 32/4/44 instance.
module tb_simon_control_2;

  localparam int T   = 32;
  localparam int M   = 4;
  localparam int LEN = 70;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       nReset, start, newKey, enc_dec;
  logic       ready, busy, kLd, kExp, pLd, rnd, done, keyValid;
  logic [4:0] count;
`ifdef SIMON_CTRL_ABORT_EN
  logic       abort;
  logic       abort44;
`endif

  logic       start44, newKey44, enc_dec44;
  logic       ready44, busy44, kLd44, kExp44, pLd44, rnd44, done44, keyValid44;
  logic [5:0] count44;

  simon_control_2 #(.N(16), .M(4), .T(32)) dut (
    .clk(clk), .nReset(nReset), .start(start), .newKey(newKey), .enc_dec(enc_dec),
`ifdef SIMON_CTRL_ABORT_EN
    .abort(abort),
`endif
    .ready(ready), .busy(busy), .kLd(kLd), .kExp(kExp), .pLd(pLd), .rnd(rnd),
    .count(count), .keyValid(keyValid), .done(done)
  );

  simon_control_2 #(.N(32), .M(4), .T(44)) dut44 (
    .clk(clk), .nReset(nReset), .start(start44), .newKey(newKey44), .enc_dec(enc_dec44),
`ifdef SIMON_CTRL_ABORT_EN
    .abort(abort44),
`endif
    .ready(ready44), .busy(busy44), .kLd(kLd44), .kExp(kExp44), .pLd(pLd44), .rnd(rnd44),
    .count(count44), .keyValid(keyValid44), .done(done44)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  typedef struct {
    bit    new_key;
    bit    enc_dec;
    bit    key_path;     // expected to go through KLD/KEXP
    bit    busy_pulses;  // extra start pulses at cycles 5 and 40
    string tag;
  } vec_t;

  vec_t vecs[5];

  // Runs one operation and checks strobes, count and keyValid every cycle.
  task automatic run_and_check(input bit nk, input bit ed, input bit kp,
                               input bit bp, input string tag);
    int         pld_c, done_c, exp_cnt, r;
    logic [6:0] exp_s, got_s;
    bit         e_kld, e_kexp, e_pld, e_rnd, e_done;
    pld_c  = kp ? (T - M + 2) : 1;
    done_c = pld_c + T + 1;
    @(negedge clk);
    start = 1'b1; newKey = nk; enc_dec = ed;
    @(negedge clk);
    start = 1'b0; newKey = 1'b0; enc_dec = 1'b0;
    for (int c = 1; c <= LEN; c++) begin
      e_kld  = kp && (c == 1);
      e_kexp = kp && (c >= 2) && (c < pld_c);
      e_pld  = (c == pld_c);
      e_rnd  = (c > pld_c) && (c <= pld_c + T);
      e_done = (c == done_c);
      exp_s  = {e_kld, e_kexp, e_pld, e_rnd, e_done, (c > done_c), (c <= done_c)};
      got_s  = {kLd, kExp, pLd, rnd, done, ready, busy};
      check($sformatf("%s strobes c%0d", tag, c), 32'(got_s), 32'(exp_s));
      exp_cnt = -1;
      if (e_kexp) exp_cnt = M + c - 2;
      if (e_rnd) begin
        r = c - pld_c - 1;
        exp_cnt = ed ? (T - 1 - r) : r;
      end
      if (c > done_c) exp_cnt = 0;
      if (exp_cnt >= 0) check($sformatf("%s count c%0d", tag, c), 32'(count), 32'(exp_cnt));
      if (c >= pld_c)
        check($sformatf("%s keyValid c%0d", tag, c), 32'(keyValid), 32'd1);
      else if (kp && c >= 2)
        check($sformatf("%s keyValid c%0d", tag, c), 32'(keyValid), 32'd0);
      if (bp) begin
        start  = (c == 5) || (c == 40);
        newKey = start;
      end
      @(negedge clk);
    end
    start = 1'b0; newKey = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int kexp_n, done_c, max_c, pld_c, done_n;

    vecs[0] = '{1'b1, 1'b0, 1'b1, 1'b0, "enc_newkey"};
    vecs[1] = '{1'b0, 1'b1, 1'b0, 1'b0, "dec_reuse"};
    vecs[2] = '{1'b0, 1'b0, 1'b0, 1'b0, "enc_reuse"};
    vecs[3] = '{1'b1, 1'b1, 1'b1, 1'b0, "dec_newkey"};
    vecs[4] = '{1'b1, 1'b0, 1'b1, 1'b1, "busy_start"};

    nReset = 1'b0; start = 1'b0; newKey = 1'b0; enc_dec = 1'b0;
    start44 = 1'b0; newKey44 = 1'b0; enc_dec44 = 1'b0;
`ifdef SIMON_CTRL_ABORT_EN
    abort = 1'b0; abort44 = 1'b0;
`endif
    #12;
    check("reset strobes", 32'({kLd, kExp, pLd, rnd, done, ready, busy}), 32'b0000010);
    check("reset keyValid", 32'(keyValid), 32'd0);
    check("reset count", 32'(count), 32'd0);
    @(negedge clk);
    nReset = 1'b1;

    for (int i = 0; i < 5; i++)
      run_and_check(vecs[i].new_key, vecs[i].enc_dec, vecs[i].key_path,
                    vecs[i].busy_pulses, vecs[i].tag);

    // Asynchronous reset in the middle of RUN.
    @(negedge clk);
    start = 1'b1; newKey = 1'b1; enc_dec = 1'b0;
    @(negedge clk);
    start = 1'b0; newKey = 1'b0;
    repeat (44) @(negedge clk);
    check("midrun rnd before reset", 32'(rnd), 32'd1);
    #2 nReset = 1'b0;
    #1;
    check("midrun reset strobes", 32'({kLd, kExp, pLd, rnd, done, ready, busy}), 32'b0000010);
    check("midrun reset keyValid", 32'(keyValid), 32'd0);
    check("midrun reset count", 32'(count), 32'd0);
    @(negedge clk);
    nReset = 1'b1;

    // newKey=0 with no valid schedule must still take the key path.
    run_and_check(1'b0, 1'b0, 1'b1, 1'b0, "forced_key");

    // 32/4/44 instance, new-key encrypt.
    @(negedge clk);
    start44 = 1'b1; newKey44 = 1'b1; enc_dec44 = 1'b0;
    @(negedge clk);
    start44 = 1'b0; newKey44 = 1'b0;
    kexp_n = 0; done_c = -1; max_c = 0; pld_c = -1;
    for (int c = 1; c <= 100; c++) begin
      if (kExp44) kexp_n++;
      if (int'(count44) > max_c) max_c = int'(count44);
      if (pLd44 && pld_c < 0) pld_c = c;
      if (done44 && done_c < 0) done_c = c;
      @(negedge clk);
    end
    check("t44 kExp cycles", 32'(kexp_n), 32'd40);
    check("t44 pLd cycle", 32'(pld_c), 32'd42);
    check("t44 done cycle", 32'(done_c), 32'd87);
    check("t44 count max", 32'(max_c), 32'd43);
    check("t44 keyValid", 32'(keyValid44), 32'd1);

`ifdef SIMON_CTRL_ABORT_EN
    // Abort during RUN at count 10 on a reused key.
    @(negedge clk);
    start = 1'b1; newKey = 1'b0; enc_dec = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (11) @(negedge clk);
    check("abort pre count", 32'(count), 32'd10);
    check("abort pre rnd", 32'(rnd), 32'd1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort strobes", 32'({kLd, kExp, pLd, rnd, done, ready, busy}), 32'b0000010);
    check("abort keyValid", 32'(keyValid), 32'd1);
    done_n = 0;
    for (int c = 0; c < 40; c++) begin
      if (done) done_n++;
      @(negedge clk);
    end
    check("abort no done", 32'(done_n), 32'd0);
`else
    done_n = 0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
